fe: RTL

FE -- requirements
Module: fe

---
 rtl/fe.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/fe.sv
// ---------------------------------------------------------------------------
// fe -- instruction fetch front end
//
// Sends sequential fetch requests to instruction memory. It keeps at most two
// requests either in flight or buffered. Returned instructions are presented
// to the decode stage through a registered output. A taken branch or jump
// (redirect) restarts fetch at a new PC. Responses that still belong to the
// old stream are dropped.
//
// Parameters
//   ADDR_W     address width
//   INSTR_W    instruction width
//   RESET_PC   first fetch address after reset
//   NOP_INSTR  bubble instruction shown on o_instr when o_valid is low
//
// Ports
//   clk               clock, all state on rising edge
//   clr               asynchronous active-high reset
//   stall             decode not accepting; output register is held
//   i_redirect_en     restart fetch at i_redirect_pc
//   i_redirect_pc     redirect target (word aligned)
//   o_imem_req_valid  fetch request valid
//   o_imem_req_addr   fetch address
//   i_imem_req_ready  memory accepts request (fire = valid & ready)
//   i_imem_rsp_valid  read data returned, in request order
//   i_imem_rsp_data   returned instruction
//   o_pc              PC of o_instr
//   o_instr           instruction to decode
//   o_valid           o_instr is a real fetched instruction
// ---------------------------------------------------------------------------
module fe #(
  parameter int                 ADDR_W    = 32,
  parameter int                 INSTR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC  = 32'h0000_0000,
  parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               stall,
  input  logic               i_redirect_en,
  input  logic [ADDR_W-1:0]  i_redirect_pc,
  output logic               o_imem_req_valid,
  output logic [ADDR_W-1:0]  o_imem_req_addr,
  input  logic               i_imem_req_ready,
  input  logic               i_imem_rsp_valid,
  input  logic [INSTR_W-1:0] i_imem_rsp_data,
  output logic [ADDR_W-1:0]  o_pc,
  output logic [INSTR_W-1:0] o_instr,
  output logic               o_valid
);

  localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

  logic [ADDR_W-1:0]  pc_q;
  logic [1:0]         inflight_q;
  logic [1:0]         discard_q;
  logic [1:0]         fifo_count_q;
  logic [ADDR_W-1:0]  fifo_pc_q    [2];
  logic [INSTR_W-1:0] fifo_instr_q [2];

  logic [2:0]         credit_used;
  logic               fire;
  logic               rsp_accept;
  logic [1:0]         inflight_next;
  logic [ADDR_W-1:0]  rsp_pc;
  logic               push;
  logic               pop;

  // Credit: a request may only be issued when its instruction is guaranteed a
  // FIFO slot, so in-flight plus buffered never exceeds the FIFO depth.
  assign credit_used      = {1'b0, inflight_q} + {1'b0, fifo_count_q};
  assign o_imem_req_valid = (credit_used < 3'd2);
  assign o_imem_req_addr  = pc_q;
  assign fire             = o_imem_req_valid & i_imem_req_ready;

  // A response with nothing outstanding is stale (e.g. issued before a reset).
  assign rsp_accept    = i_imem_rsp_valid & (inflight_q != 2'd0);
  assign inflight_next = inflight_q + {1'b0, fire} - {1'b0, rsp_accept};

  // Outstanding requests that are kept were issued back to back and end just
  // below pc_q. The oldest one, which is the one responding now, therefore
  // sits inflight_q words behind pc_q. Discarded requests are never pushed,
  // so this only matters when discard_q is zero.
  assign rsp_pc = pc_q - ADDR_W'({inflight_q, 2'b00});

  assign push = rsp_accept & (discard_q == 2'd0) & ~i_redirect_en;
  assign pop  = ~stall & ~i_redirect_en & (fifo_count_q != 2'd0);

  // Fetch PC, outstanding count and the number of old-stream responses still
  // to drop. On a redirect, everything outstanding after this edge belongs to
  // the old stream. That includes a request firing in the same cycle.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      pc_q       <= RESET_PC;
      inflight_q <= 2'd0;
      discard_q  <= 2'd0;
    end else begin
      inflight_q <= inflight_next;
      if (i_redirect_en) begin
        pc_q      <= i_redirect_pc;
        discard_q <= inflight_next;
      end else begin
        if (fire) begin
          pc_q <= pc_q + PC_STEP;
        end
        if (rsp_accept && (discard_q != 2'd0)) begin
          discard_q <= discard_q - 2'd1;
        end
      end
    end
  end

  // Two-entry in-order FIFO of {pc, instr}. Entry 0 is always the head.
  // The credit rule means a push only happens with at most one entry present.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      fifo_count_q    <= 2'd0;
      fifo_pc_q[0]    <= '0;
      fifo_pc_q[1]    <= '0;
      fifo_instr_q[0] <= '0;
      fifo_instr_q[1] <= '0;
    end else if (i_redirect_en) begin
      fifo_count_q <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          fifo_pc_q[fifo_count_q[0]]    <= rsp_pc;
          fifo_instr_q[fifo_count_q[0]] <= i_imem_rsp_data;
          fifo_count_q                  <= fifo_count_q + 2'd1;
        end
        2'b01: begin
          fifo_pc_q[0]    <= fifo_pc_q[1];
          fifo_instr_q[0] <= fifo_instr_q[1];
          fifo_count_q    <= fifo_count_q - 2'd1;
        end
        2'b11: begin
          if (fifo_count_q == 2'd1) begin
            fifo_pc_q[0]    <= rsp_pc;
            fifo_instr_q[0] <= i_imem_rsp_data;
          end else begin
            fifo_pc_q[0]    <= fifo_pc_q[1];
            fifo_instr_q[0] <= fifo_instr_q[1];
            fifo_pc_q[1]    <= rsp_pc;
            fifo_instr_q[1] <= i_imem_rsp_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Output register toward decode. A redirect inserts a bubble even when
  // decode is stalled. o_pc keeps its last value while showing a bubble.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      o_pc    <= '0;
      o_instr <= NOP_INSTR;
      o_valid <= 1'b0;
    end else if (i_redirect_en) begin
      o_instr <= NOP_INSTR;
      o_valid <= 1'b0;
    end else if (!stall) begin
      if (fifo_count_q != 2'd0) begin
        o_pc    <= fifo_pc_q[0];
        o_instr <= fifo_instr_q[0];
        o_valid <= 1'b1;
      end else begin
        o_instr <= NOP_INSTR;
        o_valid <= 1'b0;
      end
    end
  end

endmodule
